seq_pattern_detector: RTL and testbench
=======================================

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 Parameter SYM_W, default 3, symbol width in bits (1..8).
REQ-002 Parameter SEQ_LEN, default 8, pattern length in symbols (2..16).
REQ-003 Parameter CNT_W, default 16, match counter width.
REQ-004 The module SHALL use reset reset_n, asynchronous, active-low, and clock clk.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port reset_n  input  1  asynchronous active-low reset.
REQ-007 Port arm  input  1  pulse: latch pattern and overlap_en, clear history, start hunting.
REQ-008 Port disarm  input  1  pulse: return to IDLE.
REQ-009 Port pattern  input  SEQ_LEN*SYM_W  expected sequence; symbol k at bits [k*SYM_W +: SYM_W], symbol 0 is received first.
REQ-010 Port overlap_en  input  1  1 = overlapping matches allowed, 0 = history cleared after each match.
REQ-011 Port in_valid  input  1  in_data carries a symbol this cycle.
REQ-012 Port in_data  input  SYM_W  input symbol.
REQ-013 Port clear_cnt  input  1  synchronous clear of match_count and cnt_sat.
REQ-014 Port match  output  1  registered one-cycle pulse per detected sequence.
REQ-015 Port match_count  output  CNT_W  saturating count of matches.
REQ-016 Port cnt_sat  output  1  sticky flag, match_count saturated.
REQ-017 Port busy  output  1  high when state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, FILL (fewer than SEQ_LEN-1 symbols held) and HUNT (SEQ_LEN-1 symbols held).
REQ-019 arm SHALL latch pattern and overlap_en into internal registers, zero the fill count, and enter FILL from any state; pattern changes while armed SHALL have no effect.
REQ-020 disarm SHALL enter IDLE from any state; arm wins if both are asserted together.
REQ-021 In IDLE, and in any cycle with arm or disarm asserted, in_valid symbols SHALL be ignored.
REQ-022 In FILL, each accepted symbol SHALL be shifted into history and the fill count incremented; at fill = SEQ_LEN-1 the FSM SHALL enter HUNT.
REQ-023 In HUNT, an accepted symbol SHALL be compared, together with the SEQ_LEN-1 held symbols, against the latched pattern; on equality match SHALL be high exactly one cycle after that clock edge.
REQ-024 Cycles with in_valid low SHALL leave history, fill count and state unchanged; gaps SHALL NOT break a sequence.
REQ-025 On a match with overlap_en latched 1, the FSM SHALL stay in HUNT with the window shifted.
REQ-026 On a match with overlap_en latched 0, history and fill count SHALL be cleared and the FSM SHALL enter FILL.
REQ-027 On a non-matching symbol in HUNT, the window SHALL shift and the FSM SHALL stay in HUNT (sliding-window search, no restart).
REQ-028 match_count SHALL increment on each match and hold at 2^CNT_W-1; cnt_sat SHALL set on the increment that reaches 2^CNT_W-1 and stay set.
REQ-029 clear_cnt SHALL zero match_count and cnt_sat; if a match occurs in the same cycle, clear_cnt SHALL win and the count SHALL be 0.
REQ-030 arm and disarm SHALL NOT affect match_count or cnt_sat.

Reset
REQ-031 Reset SHALL force state IDLE, zero history, fill count and latched pattern, and drive match=0, match_count=0, cnt_sat=0, busy=0.
REQ-032 Reset asserted mid-sequence SHALL discard partial history; no match SHALL be reported for symbols received before reset.

Structure
REQ-033 A shared package seq_det_pkg SHALL hold the FSM state enum (IDLE, FILL, HUNT) and the default parameter constants.
REQ-034 The saturating counter with sticky flag SHALL be a sub-module sat_counter (parameter CNT_W; inputs inc and clr).

Verification
REQ-035 Defaults, arm with pattern 1,5,6,0,6,6,3,5, overlap_en=0; feed those 8 symbols back-to-back -> one match pulse one cycle after the 8th symbol, match_count=1.
REQ-036 Same pattern, in_valid low for 3 cycles between symbols 4 and 5 -> match still reported; feeding 1,5,6,7 and then the full sequence -> exactly one match.
REQ-037 SEQ_LEN=3, pattern 2,2,2, feed 2 five times: overlap_en=1 -> 3 matches; overlap_en=0 -> 1 match.
REQ-038 CNT_W=2, 4 matches -> match_count=3, cnt_sat=1; then clear_cnt together with a match -> match_count=0, cnt_sat=0.
REQ-039 Pulse reset_n after 7 of 8 symbols, re-arm, send the final symbol -> no match; disarm mid-sequence -> busy=0, later symbols ignored.
REQ-040 Change pattern after arm, then feed the originally latched sequence -> match; arm and in_valid together -> that symbol not counted.

Source files
------------

// File: rtl/seq_pattern_detector_pkg.sv
// Shared definitions for the sequence pattern detector: FSM state encoding
// and default parameter values.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    localparam int unsigned DEF_SYM_W   = 3;
    localparam int unsigned DEF_SEQ_LEN = 8;
    localparam int unsigned DEF_CNT_W   = 16;

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Control, symbol stream and result signals of the sequence pattern detector.
interface seq_pattern_detector_if
    import seq_det_pkg::*;
#(
    parameter int unsigned SYM_W   = DEF_SYM_W,
    parameter int unsigned SEQ_LEN = DEF_SEQ_LEN,
    parameter int unsigned CNT_W   = DEF_CNT_W
);
    logic                     arm;
    logic                     disarm;
    logic [SEQ_LEN*SYM_W-1:0] pattern;
    logic                     overlap_en;
    logic                     in_valid;
    logic [SYM_W-1:0]         in_data;
    logic                     clear_cnt;
    logic                     match;
    logic [CNT_W-1:0]         match_count;
    logic                     cnt_sat;
    logic                     busy;

    modport master (
        output arm, disarm, pattern, overlap_en, in_valid, in_data, clear_cnt,
        input  match, match_count, cnt_sat, busy
    );

    modport slave (
        input  arm, disarm, pattern, overlap_en, in_valid, in_data, clear_cnt,
        output match, match_count, cnt_sat, busy
    );

endinterface

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating event counter with a sticky flag set on the increment that
// reaches full scale; clr has priority over inc.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic [CNT_W-1:0] w_next;

    assign w_next = r_count + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (inc && (r_count != MAX)) begin
            r_count <= w_next;
            if (w_next == MAX)
                r_sat <= 1'b1;
        end
    end

    assign count = r_count;
    assign sat   = r_sat;

endmodule

// File: rtl/seq_pattern_detector.sv
// Sliding-window symbol sequence detector with optional overlapping matches
// and a saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned SYM_W   = DEF_SYM_W,
    parameter int unsigned SEQ_LEN = DEF_SEQ_LEN,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input logic                  clk,
    input logic                  reset_n,
    seq_pattern_detector_if.slave bus
);
    localparam int unsigned PAT_W  = SEQ_LEN * SYM_W;
    localparam int unsigned HIST_W = (SEQ_LEN - 1) * SYM_W;
    localparam int unsigned FILL_W = $clog2(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_LEN - 1);

    state_t              r_state;
    logic [HIST_W-1:0]   r_hist;
    logic [PAT_W-1:0]    r_pattern;
    logic                r_overlap;
    logic [FILL_W-1:0]   r_fill;
    logic                r_match;

    logic                w_accept;
    logic                w_hit;
    logic                w_match_now;
    logic [PAT_W-1:0]    w_window;
    logic [HIST_W-1:0]   w_hist_shift;

    // Oldest held symbol sits in the low bits, so the window lines up with
    // the pattern layout (symbol 0 at bit 0) and shifting drops the low symbol.
    assign w_window     = {bus.in_data, r_hist};
    assign w_hist_shift = w_window[PAT_W-1:SYM_W];
    assign w_hit        = (w_window == r_pattern);
    assign w_accept     = bus.in_valid && !bus.arm && !bus.disarm && (r_state != IDLE);
    assign w_match_now  = w_accept && (r_state == HUNT) && w_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_hist    <= '0;
            r_pattern <= '0;
            r_overlap <= 1'b0;
            r_fill    <= '0;
            r_match   <= 1'b0;
        end else begin
            r_match <= w_match_now;
            if (bus.arm) begin
                r_state   <= FILL;
                r_pattern <= bus.pattern;
                r_overlap <= bus.overlap_en;
                r_hist    <= '0;
                r_fill    <= '0;
            end else if (bus.disarm) begin
                r_state <= IDLE;
            end else if (w_accept) begin
                case (r_state)
                    FILL: begin
                        r_hist <= w_hist_shift;
                        r_fill <= r_fill + 1'b1;
                        if (r_fill + 1'b1 == FILL_LAST)
                            r_state <= HUNT;
                    end
                    HUNT: begin
                        if (w_hit && !r_overlap) begin
                            r_hist  <= '0;
                            r_fill  <= '0;
                            r_state <= FILL;
                        end else begin
                            r_hist <= w_hist_shift;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_sat_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_match_now),
        .clr     (bus.clear_cnt),
        .count   (bus.match_count),
        .sat     (bus.cnt_sat)
    );

    assign bus.match = r_match;
    assign bus.busy  = (r_state != IDLE);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios plus random traffic,
// checked against a queue-based model of the last received symbols.
module tb_seq_pattern_detector;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    int sel    = 0;
    int m_len  = 8;
    int m_symw = 3;
    int m_max  = 65535;

    int pat_cur[16];
    bit tb_ov;
    int P[8] = '{1, 5, 6, 0, 6, 6, 3, 5};

    int m_pat[16];
    int m_q[$];
    int m_cnt;
    bit m_ov, m_armed, m_sat, m_match;

    always #5 clk = ~clk;

    seq_pattern_detector_if #(.SYM_W(3), .SEQ_LEN(8), .CNT_W(16)) bus0 ();
    seq_pattern_detector_if #(.SYM_W(2), .SEQ_LEN(3), .CNT_W(2))  bus1 ();

    seq_pattern_detector #(.SYM_W(3), .SEQ_LEN(8), .CNT_W(16)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    seq_pattern_detector #(.SYM_W(2), .SEQ_LEN(3), .CNT_W(2)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit a, input bit dis, input bit v, input int d, input bit clr);
        bus0.arm = 1'b0; bus0.disarm = 1'b0; bus0.in_valid = 1'b0; bus0.in_data = '0;
        bus0.clear_cnt = 1'b0; bus0.overlap_en = 1'b0;
        bus1.arm = 1'b0; bus1.disarm = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0;
        bus1.clear_cnt = 1'b0; bus1.overlap_en = 1'b0;
        if (sel == 0) begin
            bus0.arm = a; bus0.disarm = dis; bus0.in_valid = v; bus0.in_data = 3'(d);
            bus0.clear_cnt = clr; bus0.overlap_en = tb_ov;
            for (int k = 0; k < 8; k++) bus0.pattern[k*3 +: 3] = 3'(pat_cur[k]);
            bus1.pattern = '0;
        end else begin
            bus1.arm = a; bus1.disarm = dis; bus1.in_valid = v; bus1.in_data = 2'(d);
            bus1.clear_cnt = clr; bus1.overlap_en = tb_ov;
            for (int k = 0; k < 3; k++) bus1.pattern[k*2 +: 2] = 2'(pat_cur[k]);
            bus0.pattern = '0;
        end
    endtask

    // Reference: the last m_len accepted symbols compared against the latched pattern.
    task automatic model_step(input bit a, input bit dis, input bit v, input int d, input bit clr);
        bit hit;
        hit = 1'b0;
        if (a) begin
            m_armed = 1'b1;
            m_ov    = tb_ov;
            for (int k = 0; k < 16; k++) m_pat[k] = pat_cur[k] & ((1 << m_symw) - 1);
            m_q.delete();
        end else if (dis) begin
            m_armed = 1'b0;
        end else if (m_armed && v) begin
            m_q.push_back(d);
            if (m_q.size() > m_len) void'(m_q.pop_front());
            if (m_q.size() == m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (m_q[k] != m_pat[k]) hit = 1'b0;
            end
            if (hit && !m_ov) m_q.delete();
        end
        m_match = hit;
        if (clr) begin
            m_cnt = 0;
            m_sat = 1'b0;
        end else if (hit && m_cnt < m_max) begin
            m_cnt++;
            if (m_cnt == m_max) m_sat = 1'b1;
        end
    endtask

    task automatic check_outputs();
        if (sel == 0) begin
            check_eq("match", 32'(bus0.match), 32'(m_match));
            check_eq("count", 32'(bus0.match_count), 32'(m_cnt));
            check_eq("sat",   32'(bus0.cnt_sat), 32'(m_sat));
            check_eq("busy",  32'(bus0.busy), 32'(m_armed));
        end else begin
            check_eq("match", 32'(bus1.match), 32'(m_match));
            check_eq("count", 32'(bus1.match_count), 32'(m_cnt));
            check_eq("sat",   32'(bus1.cnt_sat), 32'(m_sat));
            check_eq("busy",  32'(bus1.busy), 32'(m_armed));
        end
    endtask

    task automatic cyc(input bit a, input bit dis, input bit v, input int d, input bit clr);
        int dm;
        dm = d & ((1 << m_symw) - 1);
        drive(a, dis, v, dm, clr);
        @(posedge clk);
        model_step(a, dis, v, dm, clr);
        #1;
        check_outputs();
    endtask

    task automatic feed(input int s);
        cyc(1'b0, 1'b0, 1'b1, s, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        reset_n = 1'b0;
        #1;
        m_armed = 1'b0; m_q.delete(); m_cnt = 0; m_sat = 1'b0; m_match = 1'b0;
        check_outputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic random_cycle();
        int r;
        bit a, dis, v, clr;
        int d;
        r   = int'($urandom_range(0, 99));
        a   = (r < 3);
        dis = (r >= 3 && r < 6) || (r == 0);
        clr = ($urandom_range(0, 49) == 0);
        v   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) != 0) d = m_pat[m_q.size() % m_len];
        else d = int'($urandom);
        if (a) begin
            tb_ov = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0)
                for (int k = 0; k < m_len; k++) pat_cur[k] = int'($urandom_range(0, (1 << m_symw) - 1));
        end
        cyc(a, dis, v, d, clr);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin pat_cur[k] = 0; m_pat[k] = 0; end
        for (int k = 0; k < 8; k++) pat_cur[k] = P[k];
        tb_ov = 1'b0;
        sel = 0; m_len = 8; m_symw = 3; m_max = 65535;
        do_reset();

        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 8; k++) feed(P[k]);
        check_eq("single_match", 32'(bus0.match), 1);
        check_eq("single_cnt", 32'(bus0.match_count), 1);
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
        check_eq("pulse_width", 32'(bus0.match), 0);

        for (int k = 0; k < 4; k++) feed(P[k]);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 7, 1'b0);
        for (int k = 4; k < 8; k++) feed(P[k]);
        check_eq("gap_cnt", 32'(bus0.match_count), 2);

        feed(1); feed(5); feed(6); feed(7);
        for (int k = 0; k < 8; k++) feed(P[k]);
        check_eq("prefix_cnt", 32'(bus0.match_count), 3);

        for (int k = 0; k < 7; k++) feed(P[k]);
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        feed(P[7]);
        check_eq("rst_mid_match", 32'(bus0.match), 0);
        check_eq("rst_mid_cnt", 32'(bus0.match_count), 0);

        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 3; k++) feed(P[k]);
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        check_eq("disarm_busy", 32'(bus0.busy), 0);
        for (int k = 3; k < 8; k++) feed(P[k]);
        check_eq("disarm_cnt", 32'(bus0.match_count), 0);

        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 8; k++) pat_cur[k] = (P[k] + 1) % 8;
        for (int k = 0; k < 8; k++) feed(P[k]);
        check_eq("latched_pat_cnt", 32'(bus0.match_count), 1);
        for (int k = 0; k < 8; k++) pat_cur[k] = P[k];

        cyc(1'b1, 1'b0, 1'b1, P[0], 1'b0);
        for (int k = 1; k < 8; k++) feed(P[k]);
        check_eq("arm_valid_cnt", 32'(bus0.match_count), 1);

        repeat (400) random_cycle();

        sel = 1; m_len = 3; m_symw = 2; m_max = 3;
        for (int k = 0; k < 16; k++) pat_cur[k] = 0;
        for (int k = 0; k < 3; k++) pat_cur[k] = 2;
        tb_ov = 1'b1;
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat (5) feed(2);
        check_eq("ovl_on_cnt", 32'(bus1.match_count), 3);

        cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);
        tb_ov = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat (5) feed(2);
        check_eq("ovl_off_cnt", 32'(bus1.match_count), 1);

        cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat (12) feed(2);
        check_eq("sat_cnt", 32'(bus1.match_count), 3);
        check_eq("sat_flag", 32'(bus1.cnt_sat), 1);
        feed(2); feed(2);
        cyc(1'b0, 1'b0, 1'b1, 2, 1'b1);
        check_eq("clr_win_match", 32'(bus1.match), 1);
        check_eq("clr_win_cnt", 32'(bus1.match_count), 0);
        check_eq("clr_win_sat", 32'(bus1.cnt_sat), 0);

        repeat (400) random_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
